mips32_ex_stage: RTL

MIPS32_EX_STAGE -- requirements
Module: mips32_ex_stage

---
 rtl/mips32_pkg.sv | 84 ++++++++
 rtl/mips32_ex_stage_if.sv | 39 +++
 rtl/mips32_iter_mul.sv | 57 +++++
 rtl/mips32_ex_stage.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Shared MIPS32 pipeline definitions: datapath widths, opcodes, instruction
// classes, the EX result payload and the EX ALU helper function.
// Imported by every pipeline stage.
package mips32_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 6;

  // Opcodes live in ir[31:26]
  localparam logic [OPC_W-1:0] OP_ADD   = 6'h00;
  localparam logic [OPC_W-1:0] OP_SUB   = 6'h01;
  localparam logic [OPC_W-1:0] OP_AND   = 6'h02;
  localparam logic [OPC_W-1:0] OP_OR    = 6'h04;
  localparam logic [OPC_W-1:0] OP_SLT   = 6'h05;
  localparam logic [OPC_W-1:0] OP_MUL   = 6'h06;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'h0A;
  localparam logic [OPC_W-1:0] OP_SUBI  = 6'h0B;
  localparam logic [OPC_W-1:0] OP_SLTI  = 6'h0C;
  localparam logic [OPC_W-1:0] OP_BNEQZ = 6'h0D;
  localparam logic [OPC_W-1:0] OP_BEQZ  = 6'h0E;
  localparam logic [OPC_W-1:0] OP_HLT   = 6'h3F;

  typedef enum logic [2:0] {
    RR_ALU = 3'd0,
    RI_ALU = 3'd1,
    LOAD   = 3'd2,
    STORE  = 3'd3,
    BRANCH = 3'd4,
    HALT   = 3'd7
  } reg_type_t;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_BUSY = 1'b1
  } ex_state_t;

  // One EX->MEM result as produced in the acceptance cycle
  typedef struct packed {
    logic [XLEN-1:0] aluout;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] ir;
    logic            cond;
    logic [2:0]      reg_type;
    logic            taken;
  } ex_result_t;

  // Single-cycle ALU; MUL is handled by the caller, unknown ops give 0
  function automatic logic [XLEN-1:0] alu_compute(
    input reg_type_t        rt,
    input logic [OPC_W-1:0] op,
    input logic [XLEN-1:0]  a,
    input logic [XLEN-1:0]  b,
    input logic [XLEN-1:0]  imm,
    input logic [XLEN-1:0]  npc
  );
    logic [XLEN-1:0] r;
    r = '0;
    case (rt)
      RR_ALU: begin
        case (op)
          OP_ADD:  r = a + b;
          OP_SUB:  r = a - b;
          OP_AND:  r = a & b;
          OP_OR:   r = a | b;
          OP_SLT:  r = ($signed(a) < $signed(b)) ? XLEN'(1) : '0;
          default: r = '0;
        endcase
      end
      RI_ALU: begin
        case (op)
          OP_ADDI: r = a + imm;
          OP_SUBI: r = a - imm;
          OP_SLTI: r = ($signed(a) < $signed(imm)) ? XLEN'(1) : '0;
          default: r = '0;
        endcase
      end
      LOAD, STORE: r = a + imm;
      BRANCH:      r = npc + imm;
      default:     r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips32_ex_stage_if.sv
// ID/EX -> EX -> EX/MEM bundle for the MIPS32 execute stage.
// master: upstream/downstream environment (drives instruction + mem_stall).
// slave : the EX stage (drives ex_ready, ex_mem_*, branch_taken, halted).
interface mips32_ex_stage_if;

  logic        id_ex_valid;
  logic        ex_ready;
  logic [31:0] id_ex_ir;
  logic [31:0] id_ex_a;
  logic [31:0] id_ex_b;
  logic [31:0] id_ex_imm;
  logic [31:0] id_ex_npc;
  logic [2:0]  id_ex_reg_type;
  logic        mem_stall;

  logic        ex_mem_valid;
  logic [31:0] ex_mem_aluout;
  logic [31:0] ex_mem_b;
  logic [31:0] ex_mem_ir;
  logic        ex_mem_cond;
  logic [2:0]  ex_mem_reg_type;
  logic        branch_taken;
  logic        halted;

  modport master (
    output id_ex_valid, id_ex_ir, id_ex_a, id_ex_b, id_ex_imm, id_ex_npc,
           id_ex_reg_type, mem_stall,
    input  ex_ready, ex_mem_valid, ex_mem_aluout, ex_mem_b, ex_mem_ir,
           ex_mem_cond, ex_mem_reg_type, branch_taken, halted
  );

  modport slave (
    input  id_ex_valid, id_ex_ir, id_ex_a, id_ex_b, id_ex_imm, id_ex_npc,
           id_ex_reg_type, mem_stall,
    output ex_ready, ex_mem_valid, ex_mem_aluout, ex_mem_b, ex_mem_ir,
           ex_mem_cond, ex_mem_reg_type, branch_taken, halted
  );

endinterface

// File: rtl/mips32_iter_mul.sv
// Iterative shift-add multiplier, low 32 bits of a*b, BITS_PER_CYCLE
// multiplier bits per cycle (1, 2, 4 or 8).
// Ports: clk, rst (async active-high), start (load operands), a, b,
//        ack (consumer takes the result while done), done (result valid,
//        held until ack), product.
// The first partial product is folded into the start cycle so done rises
// exactly 32/BITS_PER_CYCLE cycles after start.
module mips32_iter_mul #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ack,
  output logic        done,
  output logic [31:0] product
);

  localparam int unsigned STEPS = 32 / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = 6;

  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      acc;
  logic [31:0]      mcand;
  logic [31:0]      mplier;

  assign done    = busy && (cnt == '0);
  assign product = acc;

  // Operand load with first step, then one slice per cycle until done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= CNT_W'(STEPS - 1);
      acc    <= a * 32'(b[BITS_PER_CYCLE-1:0]);
      mcand  <= a << BITS_PER_CYCLE;
      mplier <= b >> BITS_PER_CYCLE;
    end else if (busy && (cnt != '0)) begin
      cnt    <= cnt - CNT_W'(1);
      acc    <= acc + mcand * 32'(mplier[BITS_PER_CYCLE-1:0]);
      mcand  <= mcand << BITS_PER_CYCLE;
      mplier <= mplier >> BITS_PER_CYCLE;
    end else if (done && ack) begin
      busy   <= 1'b0;
    end
  end

endmodule

// File: rtl/mips32_ex_stage.sv
// MIPS32 execute stage: ALU, address and branch-target generation, branch
// resolution, HLT latching and MUL (iterative by default).
// Ports: clock_1, reset (async active-high), bus (mips32_ex_stage_if.slave):
//   id_ex_* instruction in with id_ex_valid/ex_ready, mem_stall from MEM,
//   ex_mem_* registered result, branch_taken, halted.
// Build option: define MIPS32_FAST_MUL_EN for a single-cycle combinational
// MUL; MUL_BITS_PER_CYCLE is then ignored.
module mips32_ex_stage
  import mips32_pkg::*;
#(
  parameter int unsigned MUL_BITS_PER_CYCLE = 1
) (
  input  logic              clock_1,
  input  logic              reset,
  mips32_ex_stage_if.slave  bus
);

  ex_state_t   state;
  logic        halted_q;
  logic        valid_q;
  logic [31:0] aluout_q;
  logic [31:0] b_q;
  logic [31:0] ir_q;
  logic        cond_q;
  logic [2:0]  rtype_q;
  logic        taken_q;

  // MUL context kept while the multiplier runs
  logic [31:0] mul_ir_q;
  logic [31:0] mul_b_q;
  logic        mul_cond_q;

  logic [OPC_W-1:0] opcode;
  reg_type_t        rtype;
  logic             ready_c;
  logic             accept_c;
  logic             is_mul_c;
  ex_result_t       res_c;

  logic             mul_done;
  logic [31:0]      mul_product;

  assign opcode   = bus.id_ex_ir[31:26];
  assign rtype    = reg_type_t'(bus.id_ex_reg_type);
  assign ready_c  = !reset && (state == RUN) && !bus.mem_stall && !halted_q;
  assign accept_c = bus.id_ex_valid && ready_c;
  assign is_mul_c = (rtype == RR_ALU) && (opcode == OP_MUL);

`ifdef MIPS32_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`else
  localparam bit FAST_MUL = 1'b0;
  logic mul_start;
  logic mul_ack;
  assign mul_start = accept_c && is_mul_c;
  assign mul_ack   = !bus.mem_stall;

  mips32_iter_mul #(
    .BITS_PER_CYCLE (MUL_BITS_PER_CYCLE)
  ) u_iter_mul (
    .clk     (clock_1),
    .rst     (reset),
    .start   (mul_start),
    .a       (bus.id_ex_a),
    .b       (bus.id_ex_b),
    .ack     (mul_ack),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  // Result of the instruction currently presented
  always_comb begin
    res_c          = '0;
    res_c.aluout   = alu_compute(rtype, opcode, bus.id_ex_a, bus.id_ex_b,
                                 bus.id_ex_imm, bus.id_ex_npc);
    if (FAST_MUL && is_mul_c) res_c.aluout = bus.id_ex_a * bus.id_ex_b;
    res_c.b        = bus.id_ex_b;
    res_c.ir       = bus.id_ex_ir;
    res_c.cond     = (bus.id_ex_a == '0);
    res_c.reg_type = bus.id_ex_reg_type;
    res_c.taken    = (rtype == BRANCH) &&
                     (((opcode == OP_BEQZ)  && (bus.id_ex_a == '0)) ||
                      ((opcode == OP_BNEQZ) && (bus.id_ex_a != '0)));
  end

  // Stage FSM and EX/MEM register; a stall freezes every output
  always_ff @(posedge clock_1 or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      halted_q   <= 1'b0;
      valid_q    <= 1'b0;
      aluout_q   <= '0;
      b_q        <= '0;
      ir_q       <= '0;
      cond_q     <= 1'b0;
      rtype_q    <= '0;
      taken_q    <= 1'b0;
      mul_ir_q   <= '0;
      mul_b_q    <= '0;
      mul_cond_q <= 1'b0;
    end else begin
      if (!bus.mem_stall) begin
        valid_q <= 1'b0;
        taken_q <= 1'b0;
      end
      case (state)
        RUN: begin
          if (accept_c) begin
            if (is_mul_c && !FAST_MUL) begin
              state      <= MUL_BUSY;
              mul_ir_q   <= res_c.ir;
              mul_b_q    <= res_c.b;
              mul_cond_q <= res_c.cond;
            end else begin
              valid_q  <= 1'b1;
              aluout_q <= res_c.aluout;
              b_q      <= res_c.b;
              ir_q     <= res_c.ir;
              cond_q   <= res_c.cond;
              rtype_q  <= res_c.reg_type;
              taken_q  <= res_c.taken;
              if (rtype == HALT) halted_q <= 1'b1;
            end
          end
        end
        MUL_BUSY: begin
          if (mul_done && !bus.mem_stall) begin
            state    <= RUN;
            valid_q  <= 1'b1;
            aluout_q <= mul_product;
            b_q      <= mul_b_q;
            ir_q     <= mul_ir_q;
            cond_q   <= mul_cond_q;
            rtype_q  <= 3'(RR_ALU);
            taken_q  <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.ex_ready        = ready_c;
  assign bus.ex_mem_valid    = valid_q;
  assign bus.ex_mem_aluout   = aluout_q;
  assign bus.ex_mem_b        = b_q;
  assign bus.ex_mem_ir       = ir_q;
  assign bus.ex_mem_cond     = cond_q;
  assign bus.ex_mem_reg_type = rtype_q;
  assign bus.branch_taken    = taken_q;
  assign bus.halted          = halted_q;

endmodule
